// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin issue of requester operations to a shared pipelined
//            ALU, with an in-order tagged response FIFO and credit flow control.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int NREQ       = 4,
  parameter int RESP_DEPTH = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic                 alu_in_valid,
  input  logic [31:0]          alu_out,
  input  logic                 alu_out_valid,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_id,
  output logic [31:0]          resp_data,
  output logic                 err
);

  localparam int c_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(RESP_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(RESP_DEPTH - 1);

  logic [1:0]         r_rr_ptr;
  logic [c_CNT_W-1:0] r_credit;
  logic [1:0]         w_win_id;
  logic [1:0]         w_idx;
  logic               w_any;
  logic               w_accept;

  logic [1:0]         r_tag_id [ALU_LAT+1];
  logic [ALU_LAT:0]   r_tag_vld;
  logic               w_head_vld;
  logic [1:0]         w_head_id;

  logic [33:0]        r_mem [RESP_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_full;
  logic               w_push_try;
  logic               w_push;
  logic               w_pop;
  logic               w_err_set;

  function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or above rr_ptr, wrapping 3 -> 0
  always_comb begin
    w_any    = 1'b0;
    w_win_id = r_rr_ptr;
    w_idx    = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_any && req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_win_id = w_idx;
      end
    end
  end

  assign w_accept  = w_any && (r_credit < c_DEPTH) && !rst;
  assign req_ready = w_accept ? (NREQ'(1) << w_win_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      alu_in_valid <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
    end else begin
      alu_in_valid <= w_accept;
      if (w_accept) begin
        r_rr_ptr <= w_win_id + 2'd1;
        alu_a    <= req_a[32*w_win_id +: 32];
        alu_b    <= req_b[32*w_win_id +: 32];
      end
    end
  end

  // Tag pipeline: head stage lines up with alu_out_valid of the same operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_accept;
      for (int k = 1; k <= ALU_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_win_id;
    for (int k = 1; k <= ALU_LAT; k++) begin
      r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  assign w_head_vld = r_tag_vld[ALU_LAT];
  assign w_head_id  = r_tag_id[ALU_LAT];

  assign w_full     = (r_count == c_DEPTH);
  assign w_push_try = alu_out_valid && w_head_vld;
  assign w_push     = w_push_try && !w_full;
  assign w_pop      = resp_valid && resp_ready;
  assign w_err_set  = (alu_out_valid != w_head_vld) || (w_push_try && w_full);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_head_id, alu_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= '0;
      err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
      if (w_err_set) err <= 1'b1;
    end
  end

  // Head is masked so the channel reads zero while empty or in reset
  assign resp_valid = (r_count != '0);
  assign resp_id    = resp_valid ? r_mem[r_rd_ptr][33:32] : '0;
  assign resp_data  = resp_valid ? r_mem[r_rd_ptr][31:0]  : '0;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int RESP_DEPTH = 4;
  localparam int ALU_LAT    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic         alu_in_valid;
  logic [31:0]  alu_out;
  logic         alu_out_valid;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;
  logic         err;

  alu_arbiter #(.NREQ(4), .RESP_DEPTH(RESP_DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .err(err)
  );

  always #5 clk = ~clk;

  // External two-stage adder, plus a hook to inject a spurious result
  logic [1:0]  p_v;
  logic [31:0] p_d0, p_d1;
  logic        inj;
  logic [31:0] inj_data;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v  <= '0;
      p_d0 <= '0;
      p_d1 <= '0;
    end else begin
      p_v  <= {p_v[0], alu_in_valid};
      p_d0 <= alu_a + alu_b;
      p_d1 <= p_d0;
    end
  end
  assign alu_out_valid = p_v[1] | inj;
  assign alu_out       = inj ? inj_data : p_d1;

  typedef struct { int id; logic [31:0] data; int cyc; } exp_t;
  exp_t        q[$];
  int          pop_ids[$];
  int          rr, outstanding, cyc, n_checks, n_fail, n;
  logic        exp_err, prev_acc, t_acc;
  logic [31:0] prev_a, prev_b;
  int          t_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One clock cycle: generic checks against the model, then advance
  task automatic tick(output logic acc, output int g);
    int w;
    logic [3:0] er;
    exp_t e;
    #1;
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && req_valid[(rr + k) % 4]) w = (rr + k) % 4;
    er = (w >= 0 && outstanding < RESP_DEPTH) ? 4'(1 << w) : 4'b0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("alu_in_valid", 64'(alu_in_valid), 64'(prev_acc));
    if (prev_acc) begin
      check("alu_a", 64'(alu_a), 64'(prev_a));
      check("alu_b", 64'(alu_b), 64'(prev_b));
    end
    check("err", 64'(err), 64'(exp_err));
    if (resp_valid) begin
      if (q.size() == 0) check("resp_valid_unexpected", 64'(resp_valid), 64'(0));
      else begin
        check("resp_id", 64'(resp_id), 64'(q[0].id));
        check("resp_data", 64'(resp_data), 64'(q[0].data));
        check("resp_min_latency", 64'(cyc - q[0].cyc >= 4), 64'(1));
      end
    end
    acc = |(req_valid & req_ready);
    g = -1;
    for (int k = 0; k < 4; k++) if (req_ready[k]) g = k;
    if (resp_valid && resp_ready) begin
      pop_ids.push_back(int'(resp_id));
      if (q.size() > 0) begin
        void'(q.pop_front());
        outstanding--;
      end
    end
    if (er != 0) begin
      e.id = w; e.data = req_a[32*w +: 32] + req_b[32*w +: 32]; e.cyc = cyc;
      q.push_back(e);
      prev_acc = 1'b1; prev_a = req_a[32*w +: 32]; prev_b = req_b[32*w +: 32];
      rr = (w + 1) % 4;
      outstanding++;
    end else prev_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_alu_in_valid", 64'(alu_in_valid), 64'(0));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    check("rst_alu_b", 64'(alu_b), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hold_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;
    req_valid = 4'h0;
    q.delete();
    rr = 0; outstanding = 0; prev_acc = 1'b0; exp_err = 1'b0;
    cyc += 3;
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    inj = 1'b0; inj_data = '0;
    n_checks = 0; n_fail = 0; cyc = 0; exp_err = 1'b0; prev_acc = 1'b0;
    do_reset();

    // Single operation from requester 2: 5 + 7
    set_op(2, 32'd5, 32'd7);
    req_valid = 4'b0100;
    tick(t_acc, t_g);
    check("t1_alu_in_valid", 64'(alu_in_valid), 64'(1));
    check("t1_alu_a", 64'(alu_a), 64'(5));
    check("t1_alu_b", 64'(alu_b), 64'(7));
    req_valid = 4'b0000;
    tick(t_acc, t_g);
    tick(t_acc, t_g);
    check("t3_resp_valid", 64'(resp_valid), 64'(0));
    tick(t_acc, t_g);
    check("t4_resp_valid", 64'(resp_valid), 64'(1));
    check("t4_resp_id", 64'(resp_id), 64'(2));
    check("t4_resp_data", 64'(resp_data), 64'(12));
    check("t4_err", 64'(err), 64'(0));
    tick(t_acc, t_g);
    check("t5_resp_valid", 64'(resp_valid), 64'(0));

    // All four requesters valid: round-robin grant and response order
    do_reset();
    pop_ids.delete();
    for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
    req_valid = 4'hF;
    n = 0;
    for (int c = 0; c < 20 && n < 8; c++) begin
      tick(t_acc, t_g);
      if (t_acc) begin
        check("grant_order", 64'(t_g), 64'(n % 4));
        n++;
      end
    end
    check("grant_total", 64'(n), 64'(8));
    req_valid = 4'h0;
    repeat (12) tick(t_acc, t_g);
    check("rr_resp_count", 64'(pop_ids.size()), 64'(8));
    for (int i = 0; i < pop_ids.size(); i++) check("rr_resp_order", 64'(pop_ids[i]), 64'(i % 4));

    // Credit exhaustion with the response channel stalled
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    n = 0;
    repeat (10) begin
      tick(t_acc, t_g);
      if (t_acc) n++;
    end
    check("fill_accepts", 64'(n), 64'(4));
    #1 check("full_req_ready", 64'(req_ready), 64'(0));
    check("full_resp_valid", 64'(resp_valid), 64'(1));
    resp_ready = 1'b1;
    tick(t_acc, t_g);
    resp_ready = 1'b0;
    n = 0;
    repeat (6) begin
      tick(t_acc, t_g);
      if (t_acc) n++;
    end
    check("refill_accepts", 64'(n), 64'(1));
    req_valid = 4'h0;
    resp_ready = 1'b1;
    repeat (10) tick(t_acc, t_g);
    check("drain1_resp_valid", 64'(resp_valid), 64'(0));

    // 32-bit wrap-around from requester 1
    set_op(1, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0010;
    tick(t_acc, t_g);
    req_valid = 4'h0;
    for (int k = 0; k < 8 && !resp_valid; k++) tick(t_acc, t_g);
    check("wrap_resp_valid", 64'(resp_valid), 64'(1));
    check("wrap_resp_id", 64'(resp_id), 64'(1));
    check("wrap_resp_data", 64'(resp_data), 64'h1);
    tick(t_acc, t_g);

    // Spurious ALU result with nothing outstanding
    inj = 1'b1;
    inj_data = 32'hDEAD_BEEF;
    tick(t_acc, t_g);
    inj = 1'b0;
    exp_err = 1'b1;
    check("spur_err", 64'(err), 64'(1));
    check("spur_resp_valid", 64'(resp_valid), 64'(0));
    tick(t_acc, t_g);
    do_reset();
    check("spur_err_cleared", 64'(err), 64'(0));

    // Reset two cycles after an accept discards the operation
    set_op(3, 32'd9, 32'd9);
    req_valid = 4'b1000;
    tick(t_acc, t_g);
    req_valid = 4'h0;
    tick(t_acc, t_g);
    do_reset();
    repeat (6) tick(t_acc, t_g);
    check("rst_mid_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_mid_err", 64'(err), 64'(0));
    set_op(3, 32'd100, 32'd23);
    req_valid = 4'b1000;
    tick(t_acc, t_g);
    req_valid = 4'h0;
    for (int k = 0; k < 8 && !resp_valid; k++) tick(t_acc, t_g);
    check("post_rst_resp_valid", 64'(resp_valid), 64'(1));
    check("post_rst_resp_id", 64'(resp_id), 64'(3));
    check("post_rst_resp_data", 64'(resp_data), 64'(123));
    tick(t_acc, t_g);

    // Random traffic with random back-pressure
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick(t_acc, t_g);
    end
    req_valid = 4'h0;
    resp_ready = 1'b1;
    repeat (12) tick(t_acc, t_g);
    check("final_resp_valid", 64'(resp_valid), 64'(0));
    check("final_outstanding", 64'(q.size()), 64'(0));
    check("final_err", 64'(err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
